cpu0_memory_dma_master: RTL

//  Avalon-MM initiator that drives the s2 port of the 32K x 32 CPU0 on-chip RAM.

---
 rtl/cpu0_memory_dma_master.sv | 124 ++++++++++++
 1 files changed

// File: rtl/cpu0_memory_dma_master.sv
// Avalon-MM initiator for the CPU0 on-chip RAM s2 port.
// Runs block copy (src -> dst) or block fill (constant -> dst) jobs launched by a start pulse.
module cpu0_memory_dma_master #(
   parameter int ADDR_W = 15,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start,
   input  logic                mode,
   input  logic [ADDR_W-1:0]   src_addr,
   input  logic [ADDR_W-1:0]   dst_addr,
   input  logic [LEN_W-1:0]    length,
   input  logic [DATA_W-1:0]   fill_data,
   output logic                busy,
   output logic                done,
   output logic [ADDR_W-1:0]   address,
   output logic [DATA_W/8-1:0] byteenable,
   output logic                chipselect,
   output logic                write,
   output logic [DATA_W-1:0]   writedata,
   output logic                clken,
   input  logic [DATA_W-1:0]   readdata
);

   typedef enum logic [2:0] {IDLE, RD, RWAIT, WR, DONE} state_t;

   state_t              state, state_n;
   logic                mode_q;
   logic [ADDR_W-1:0]   src_ptr, dst_ptr;
   logic [LEN_W-1:0]    remaining;
   logic [DATA_W-1:0]   fill_q, data_q;
   logic                clken_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_n;
   end

   // Bus outputs decode only the registered state and latched job, never start.
   always_comb begin
      state_n    = state;
      busy       = 1'b0;
      done       = 1'b0;
      chipselect = 1'b0;
      write      = 1'b0;
      address    = '0;
      writedata  = '0;
      unique case (state)
         IDLE: begin
            if (start) begin
               if (length == '0) state_n = DONE;
               else if (mode)    state_n = WR;
               else              state_n = RD;
            end
         end
         RD: begin
            busy       = 1'b1;
            chipselect = 1'b1;
            address    = src_ptr;
            state_n    = RWAIT;
         end
         RWAIT: begin
            busy    = 1'b1;
            state_n = WR;
         end
         WR: begin
            busy       = 1'b1;
            chipselect = 1'b1;
            write      = 1'b1;
            address    = dst_ptr;
            writedata  = mode_q ? fill_q : data_q;
            if (remaining == LEN_W'(1)) state_n = DONE;
            else if (mode_q)            state_n = WR;
            else                        state_n = RD;
         end
         DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
      byteenable = {(DATA_W/8){chipselect}};
   end

   assign clken = clken_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mode_q    <= 1'b0;
         src_ptr   <= '0;
         dst_ptr   <= '0;
         remaining <= '0;
         fill_q    <= '0;
         data_q    <= '0;
         clken_q   <= 1'b0;
      end else begin
         clken_q <= 1'b1;
         unique case (state)
            IDLE: begin
               if (start) begin
                  mode_q    <= mode;
                  src_ptr   <= src_addr;
                  dst_ptr   <= dst_addr;
                  remaining <= length;
                  fill_q    <= fill_data;
               end
            end
            RWAIT: begin
               data_q  <= readdata;
               src_ptr <= src_ptr + ADDR_W'(1);
            end
            WR: begin
               dst_ptr   <= dst_ptr + ADDR_W'(1);
               remaining <= remaining - LEN_W'(1);
            end
            default: ;
         endcase
      end
   end

endmodule
